// File: rtl/y_writer_pkg.sv
// Shared constants for the y[] result writer: FloPoCo exception codes,
// canonical NaN, store stride and the writer FSM state type.
package y_writer_pkg;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    localparam int STRIDE_BYTES = 8;
    localparam int STRIDE_LOG2  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/flopoco_to_ieee.sv
// Combinational FloPoCo (66-bit, 2-bit exception prefix) to IEEE-754
// double converter.
module flopoco_to_ieee
    import y_writer_pkg::*;
(
    input  logic [65:0] fp,
    output logic [63:0] ieee
);

    always_comb begin
        ieee = CANON_NAN;
        unique case (fp[65:64])
            EXC_ZERO:   ieee = {fp[63], 63'd0};
            EXC_NORMAL: ieee = fp[63:0];
            EXC_INF:    ieee = {fp[63], 11'h7FF, 52'd0};
            EXC_NAN:    ieee = CANON_NAN;
        endcase
    end

endmodule

// File: rtl/std_fifo.sv
// Synchronous show-ahead FIFO; push while full is ignored,
// pop while empty is ignored.
module std_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/y_writer.sv
// Buffers converted SpMV results and stores them to y[] in order.
// Optional counters: define Y_WRITER_STATS_EN.
module y_writer
    import y_writer_pkg::*;
#(
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 32,
    parameter int ADDR_WIDTH      = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  push_in,
    input  logic [65:0]           v_in,
    input  logic                  eof,
    input  logic                  mc_rq_stall,
    output logic                  mc_req_st,
    output logic [ADDR_WIDTH-1:0] mc_req_vadr,
    output logic [63:0]           mc_req_wrd,
    input  logic                  mc_rs_push,
    output logic                  done,
    output logic                  overflow
`ifdef Y_WRITER_STATS_EN
    ,
    output logic [31:0]           stat_written,
    output logic [31:0]           stat_stall_cycles
`endif
);

    localparam int IW = ADDR_WIDTH - STRIDE_LOG2;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0] MAX_Q = (CW+1)'(MAX_OUTSTANDING);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [IW-1:0]         idx;
    logic                  cv_valid;
    logic [63:0]           cv_data;
    logic [63:0]           conv;
    logic [63:0]           fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         outstanding;
    logic [CW:0]           inflight;
    logic                  accept;
    logic                  launch;
    logic                  can_pop;
    logic                  drained;

    flopoco_to_ieee u_conv (
        .fp   (v_in),
        .ieee (conv)
    );

    std_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cv_valid),
        .din   (cv_data),
        .pop   (can_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A request issued last cycle is not yet in the counter; include it
    assign inflight = {1'b0, outstanding} + (CW+1)'(mc_req_st);
    assign accept   = (state == RUN) && push_in;
    assign launch   = ((state == IDLE) || (state == DONE)) && start;
    assign can_pop  = !fifo_empty && !mc_rq_stall && (inflight < MAX_Q);
    assign drained  = fifo_empty && !cv_valid && (inflight == '0);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start)   state_nxt = RUN;
            RUN:   if (eof)     state_nxt = DRAIN;
            DRAIN: if (drained) state_nxt = DONE;
            DONE:  if (start)   state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_valid    <= 1'b0;
            cv_data     <= '0;
            base_q      <= '0;
            idx         <= '0;
            mc_req_st   <= 1'b0;
            mc_req_vadr <= '0;
            mc_req_wrd  <= '0;
            overflow    <= 1'b0;
        end else begin
            cv_valid <= accept;
            if (accept)
                cv_data <= conv;
            if (launch) begin
                base_q <= base_addr;
                idx    <= '0;
            end else if (can_pop) begin
                idx <= idx + IW'(1);
            end
            mc_req_st <= can_pop;
            if (can_pop) begin
                mc_req_vadr <= base_q + (ADDR_WIDTH'(idx) << STRIDE_LOG2);
                mc_req_wrd  <= fifo_dout;
            end
            if (cv_valid && fifo_full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (mc_req_st && !mc_rs_push) begin
            outstanding <= outstanding + CW'(1);
        end else if (!mc_req_st && mc_rs_push && outstanding != '0) begin
            outstanding <= outstanding - CW'(1);
        end
    end

`ifdef Y_WRITER_STATS_EN
    logic ack_taken;
    assign ack_taken = mc_rs_push && (outstanding != '0 || mc_req_st);

    always_ff @(posedge clk) begin
        if (rst || launch) begin
            stat_written      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (ack_taken && stat_written != '1)
                stat_written <= stat_written + 32'd1;
            if (!fifo_empty && !can_pop && stat_stall_cycles != '1)
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_y_writer.sv
// Randomized self-checking bench for y_writer against a queue-based
// model of the expected store stream.
module tb_y_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [47:0] base_addr = '0;
    logic        push_in = 1'b0;
    logic [65:0] v_in = '0;
    logic        eof = 1'b0;
    logic        mc_rq_stall = 1'b0;
    logic        mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd;
    logic        mc_rs_push = 1'b0;
    logic        done;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;

    logic [47:0] exp_addr[$];
    logic [63:0] exp_data[$];
    logic [47:0] log_addr[$];
    logic [63:0] log_data[$];
    logic [47:0] m_base;
    longint      m_idx;
    bit          m_on = 0;

    int st_seen    = 0;
    int acks_given = 0;
    bit auto_ack   = 1;
    int manual     = 0;
    int stall_mode = 0;
    bit prev_stall = 0;

    always #5 clk = ~clk;

    y_writer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .push_in     (push_in),
        .v_in        (v_in),
        .eof         (eof),
        .mc_rq_stall (mc_rq_stall),
        .mc_req_st   (mc_req_st),
        .mc_req_vadr (mc_req_vadr),
        .mc_req_wrd  (mc_req_wrd),
        .mc_rs_push  (mc_rs_push),
        .done        (done),
        .overflow    (overflow)
    );

    function automatic logic [63:0] ref_conv(logic [65:0] v);
        case (v[65:64])
            2'd0:    return {v[63], 63'd0};
            2'd1:    return v[63:0];
            2'd2:    return {v[63], 11'h7FF, 52'd0};
            default: return 64'h7FF8_0000_0000_0000;
        endcase
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] expv);
        vectors++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Every presented store is checked against the model stream.
    always @(negedge clk) begin
        if (mc_req_st === 1'b1) begin
            st_seen++;
            log_addr.push_back(mc_req_vadr);
            log_data.push_back(mc_req_wrd);
            vectors++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL unexpected_store: got %h/%h expected none",
                         mc_req_vadr, mc_req_wrd);
            end else begin
                logic [47:0] ea;
                logic [63:0] ed;
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                if (mc_req_vadr !== ea) begin
                    errors++;
                    $display("FAIL store_addr: got %h expected %h",
                             mc_req_vadr, ea);
                end
                vectors++;
                if (mc_req_wrd !== ed) begin
                    errors++;
                    $display("FAIL store_data: got %h expected %h",
                             mc_req_wrd, ed);
                end
            end
            vectors++;
            if (prev_stall) begin
                errors++;
                $display("FAIL store_while_stalled: got 1 expected 0");
            end
            vectors++;
            if (st_seen - acks_given > 32) begin
                errors++;
                $display("FAIL outstanding_limit: got %0d expected <=32",
                         st_seen - acks_given);
            end
        end
        prev_stall = mc_rq_stall;
    end

    // Acknowledge and stall driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mc_rs_push = 1'b0;
            if (st_seen - acks_given > 0) begin
                if (auto_ack ? ($urandom_range(0, 1) == 1) : (manual > 0)) begin
                    mc_rs_push = 1'b1;
                    acks_given++;
                    if (!auto_ack)
                        manual--;
                end
            end
            case (stall_mode)
                1:       mc_rq_stall = 1'b1;
                2:       mc_rq_stall = ($urandom_range(0, 3) == 0);
                default: mc_rq_stall = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(logic [47:0] b);
        start = 1'b1;
        base_addr = b;
        m_base = b;
        m_idx = 0;
        m_on = 1;
        log_addr.delete();
        log_data.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic push(logic [65:0] v, bit last, bit keep);
        push_in = 1'b1;
        v_in = v;
        eof = last;
        if (m_on && keep) begin
            exp_addr.push_back(m_base + 48'(m_idx * 8));
            exp_data.push_back(ref_conv(v));
            m_idx++;
        end
        if (last)
            m_on = 0;
        tick();
        push_in = 1'b0;
        eof = 1'b0;
    endtask

    task automatic send_eof();
        eof = 1'b1;
        m_on = 0;
        tick();
        eof = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_model_empty"}, 64'(exp_addr.size()), 64'd0);
        tick();
    endtask

    task automatic wait_log(int n, int budget);
        int c;
        c = 0;
        while (log_addr.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        @(negedge clk);
        chk("rst_st", 64'(mc_req_st), 64'd0);
        chk("rst_vadr", 64'(mc_req_vadr), 64'd0);
        chk("rst_wrd", mc_req_wrd, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // basic write; pushes outside RUN must be ignored
        push({2'b01, 64'hDEAD_BEEF_0000_0001}, 0, 0);
        do_start(48'h1000);
        push({2'b01, 64'h3FF0_0000_0000_0000}, 0, 1);
        push({2'b01, 64'h4000_0000_0000_0000}, 1, 1);
        @(negedge clk);
        chk("basic_not_done", 64'(done), 64'd0);
        tick();
        push({2'b01, 64'h1234_0000_0000_0000}, 0, 0);
        wait_done("basic");
        chk("basic_cnt", 64'(log_addr.size()), 64'd2);
        chk("basic_a0", 64'(log_addr[0]), 64'h1000);
        chk("basic_d0", log_data[0], 64'h3FF0_0000_0000_0000);
        chk("basic_a1", 64'(log_addr[1]), 64'h1008);
        chk("basic_d1", log_data[1], 64'h4000_0000_0000_0000);

        // exception encodings
        do_start(48'h2000);
        push({2'b00, 1'b1, 63'h123}, 0, 1);
        push({2'b10, 1'b1, 63'h55}, 0, 1);
        push({2'b11, 1'b0, 63'h1}, 0, 1);
        send_eof();
        wait_done("exc");
        chk("exc_d0", log_data[0], 64'h8000_0000_0000_0000);
        chk("exc_d1", log_data[1], 64'hFFF0_0000_0000_0000);
        chk("exc_d2", log_data[2], 64'h7FF8_0000_0000_0000);

        // stall during a 5-value burst
        stall_mode = 1;
        repeat (2) tick();
        do_start(48'h3000);
        for (int i = 0; i < 5; i++)
            push({2'b01, 64'(i + 100)}, i == 4, 1);
        repeat (10) tick();
        stall_mode = 0;
        begin
            int c;
            c = 0;
            @(negedge clk);
            while (mc_req_st !== 1'b1 && c < 20) begin
                @(negedge clk);
                c++;
            end
            for (int i = 0; i < 5; i++) begin
                chk("stall_consec", 64'(mc_req_st), 64'd1);
                @(negedge clk);
            end
        end
        tick();
        wait_done("stall");
        chk("stall_cnt", 64'(log_addr.size()), 64'd5);

        // outstanding limit
        auto_ack = 0;
        manual = 0;
        do_start(48'h4000);
        for (int i = 0; i < 40; i++)
            push({2'b01, 64'(i * 3)}, i == 39, 1);
        repeat (80) tick();
        chk("limit_32", 64'(log_addr.size()), 64'd32);
        manual = 1;
        repeat (10) tick();
        chk("limit_33", 64'(log_addr.size()), 64'd33);
        auto_ack = 1;
        wait_done("limit");
        chk("limit_cnt", 64'(log_addr.size()), 64'd40);

        // overflow: 66 values into a 64-entry buffer while stalled
        stall_mode = 1;
        repeat (2) tick();
        do_start(48'h8000);
        for (int i = 0; i < 66; i++)
            push({2'b01, 64'(i + 7)}, 0, i < 64);
        send_eof();
        repeat (3) tick();
        @(negedge clk);
        chk("ovf_set", 64'(overflow), 64'd1);
        tick();
        stall_mode = 0;
        wait_done("ovf");
        chk("ovf_cnt", 64'(log_addr.size()), 64'd64);
        chk("ovf_last_addr", 64'(log_addr[63]), 64'h8000 + 64'd504);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // reset mid-run: 4 outstanding, 10 buffered
        auto_ack = 0;
        manual = 0;
        do_start(48'h9000);
        for (int i = 0; i < 4; i++)
            push({2'b01, 64'(i)}, 0, 1);
        wait_log(4, 30);
        stall_mode = 1;
        repeat (2) tick();
        for (int i = 0; i < 10; i++)
            push({2'b01, 64'(i + 50)}, 0, 1);
        repeat (3) tick();
        rst = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        m_on = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("mid_rst_st", 64'(mc_req_st), 64'd0);
        chk("mid_rst_vadr", 64'(mc_req_vadr), 64'd0);
        chk("mid_rst_wrd", mc_req_wrd, 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        stall_mode = 0;
        acks_given = st_seen - 1;
        manual = 1;
        repeat (10) tick();
        auto_ack = 1;
        do_start(48'h5000_0000);
        for (int i = 0; i < 3; i++)
            push({2'b01, 64'(i + 9)}, i == 2, 1);
        wait_done("rst_new");
        chk("rst_new_a0", 64'(log_addr[0]), 64'h5000_0000);

        // randomized runs; first one wraps the address space
        stall_mode = 2;
        for (int r = 0; r < 8; r++) begin
            logic [47:0] b;
            int n;
            b = (r == 0) ? 48'hFFFF_FFFF_FFF0 :
                (48'({$urandom, $urandom}) & ~48'h7);
            n = $urandom_range(1, 20);
            do_start(b);
            for (int i = 0; i < n; i++) begin
                push({2'($urandom_range(0, 3)), $urandom, $urandom},
                     (r % 2 == 1) && (i == n - 1), 1);
                repeat ($urandom_range(0, 2)) tick();
            end
            if (r % 2 == 0)
                send_eof();
            wait_done("rand");
            chk("rand_cnt", 64'(log_addr.size()), 64'(n));
        end
        stall_mode = 0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
